// File: rtl/aes_enc_sequencer.sv
// Iterative AES-128 encryption controller: one round per clock over a single
// 128-bit state register, with round keys fetched by index from an external store.
module aes_enc_sequencer #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] plaintext,
  output logic [3:0]   rk_idx,
  input  logic [0:127] round_key,
  output logic         busy,
  output logic         done,
  output logic [0:127] ciphertext,
  output logic [0:127] dbg_state
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [0:127] blk_q, blk_d;
  logic [0:127] ct_q, ct_d;
  logic [0:127] rf;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01;
    p = x;
    for (int unsigned i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [0:127] round_fn(input logic [0:127] s, input logic mix);
    logic [7:0]   b  [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] o;
    for (int unsigned i = 0; i < 16; i++) b[i] = sbox(s[8*i +: 8]);
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        sr[4*c + r] = b[4*((c + r) % 4) + r];
    if (mix) begin
      for (int unsigned c = 0; c < 4; c++) begin
        a0 = sr[4*c];
        a1 = sr[4*c + 1];
        a2 = sr[4*c + 2];
        a3 = sr[4*c + 3];
        sr[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        sr[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        sr[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        sr[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int unsigned i = 0; i < 16; i++) o[8*i +: 8] = sr[i];
    return o;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      blk_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      ct_q    <= ct_d;
    end
  end

  // One shared round datapath; mix_columns is bypassed outside ROUND.
  always_comb rf = round_fn(blk_q, state_q == ROUND);

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    ct_d    = ct_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          blk_d   = plaintext ^ round_key;
          rnd_d   = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        blk_d = rf ^ round_key;
        if (rnd_q == 4'(NR - 1)) begin
          rnd_d   = 4'(NR);
          state_d = FINAL;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      FINAL: begin
        ct_d    = rf ^ round_key;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rk_idx = '0;
    busy   = 1'b1;
    done   = 1'b0;
    case (state_q)
      IDLE:    busy   = 1'b0;
      ROUND:   rk_idx = rnd_q;
      FINAL:   rk_idx = 4'(NR);
      DONE:    done   = 1'b1;
      default: busy   = 1'b0;
    endcase
  end

  assign ciphertext = ct_q;
  assign dbg_state  = blk_q;

endmodule

// File: tb/tb_aes_enc_sequencer.sv
// Self-checking bench for aes_enc_sequencer: byte-array AES reference model,
// per-cycle output comparison, and FIPS-197 known-answer vectors.
module tb_aes_enc_sequencer;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [127:0] plaintext, round_key, ciphertext, dbg_state;
  logic [3:0]   rk_idx;
  logic         busy, done;

  always #5 clk = ~clk;

  aes_enc_sequencer #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .plaintext(plaintext),
    .rk_idx(rk_idx), .round_key(round_key), .busy(busy), .done(done),
    .ciphertext(ciphertext), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk_tab [11];
  logic [127:0] m_sts  [10];
  logic [127:0] m_ct;

  assign round_key = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        sbox_t[x][i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Reference encryption using the current key table; records each round's state.
  task automatic model_encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_tab[0][127-8*i -: 8];
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
    m_sts[0] = v;
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[4*c+rr] = sbox_t[s[4*((c+rr)%4)+rr]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = mul(8'h02, t[4*c]) ^ mul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ mul(8'h02, t[4*c+1]) ^ mul(8'h03, t[4*c+2]) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ mul(8'h02, t[4*c+2]) ^ mul(8'h03, t[4*c+3]);
          s[4*c+3] = mul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ mul(8'h02, t[4*c+3]);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] ^= rk_tab[r][127-8*i -: 8];
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
      if (r < 10) m_sts[r] = v;
      else        m_ct     = v;
    end
  endtask

  // Cycle model: ph counts edges since the accepting edge (0 = idle).
  int           ph = 0;
  logic [127:0] m_state = '0;
  logic [127:0] m_ctreg = '0;
  bit           rst_seen = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = 0; m_state = '0; m_ctreg = '0; rst_seen = 1'b1;
    end else if (ph == 0) begin
      if (start) begin
        model_encrypt(plaintext);
        m_state = m_sts[0];
        ph = 1;
      end
    end else if (ph <= 9) begin
      m_state = m_sts[ph];
      ph++;
    end else if (ph == 10) begin
      m_ctreg = m_ct;
      ph = 11;
    end else begin
      ph = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_seen) begin
      check("busy",       128'(busy),   128'(ph != 0));
      check("done",       128'(done),   128'(ph == 11));
      check("rk_idx",     128'(rk_idx), (ph >= 1 && ph <= 10) ? 128'(ph) : 128'(0));
      check("ciphertext", ciphertext,   m_ctreg);
      check("dbg_state",  dbg_state,    m_state);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int first, output int lat);
    lat = first;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, dcnt;
    bit saw_done;
    rst_n = 1'b0; start = 1'b0; plaintext = '0;

    build_sbox();
    check("sbox_00", 128'(sbox_t[8'h00]), 128'h63);
    check("sbox_53", 128'(sbox_t[8'h53]), 128'hed);
    check("sbox_ff", 128'(sbox_t[8'hff]), 128'h16);
    expand_key(KEY_B);
    check("rk1_B",  rk_tab[1],  128'ha0fafe1788542cb123a339392a6c7605);
    check("rk10_B", rk_tab[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    model_encrypt(PT_B);
    check("model_ark0_B", m_sts[0], 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check("model_r1_B",   m_sts[1], 128'ha49c7ff2689f352b6b5bea43026a5049);
    check("model_ct_B",   m_ct,     CT_B);

    tick(); tick();
    rst_n = 1'b1;
    tick();

    // FIPS-197 App. B with intermediate states
    plaintext = PT_B; start = 1'b1;
    tick();
    start = 1'b0; plaintext = rand128();
    check("dbg_after_E0", dbg_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    tick();
    check("dbg_after_E1", dbg_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
    wait_done(1, lat);
    check("done_latency_B", 128'(lat + 1), 128'(11));
    check("ct_B", ciphertext, CT_B);
    tick();
    check("done_pulse_B", 128'(done), 128'(0));

    // FIPS-197 App. C.1 with round-key index walk
    expand_key(KEY_C);
    check("rk_idx_accept", 128'(rk_idx), 128'(0));
    plaintext = PT_C; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      check("rk_idx_seq", 128'(rk_idx), 128'(i));
      tick();
    end
    check("rk_idx_done", 128'(rk_idx), 128'(0));
    check("done_C", 128'(done), 128'(1));
    check("ct_C", ciphertext, CT_C);
    tick();

    // start during ROUND/FINAL/DONE ignored; next IDLE accepts
    expand_key(KEY_B);
    plaintext = rand128(); start = 1'b1;
    tick();
    start = 1'b0; dcnt = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (done) dcnt++;
      plaintext = rand128();
      start = (e == 2 || e == 5 || e == 9 || e == 10);
    end
    tick();
    check("ignored_start_busy", 128'(busy), 128'(0));
    check("ignored_start_dcnt", 128'(dcnt), 128'(1));
    plaintext = rand128(); start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, lat);
    check("done_latency_b2b", 128'(lat + 1), 128'(11));
    tick();

    // reset at E5 aborts the block
    plaintext = PT_B; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_busy", 128'(busy),   128'(0));
    check("rst_done", 128'(done),   128'(0));
    check("rst_ct",   ciphertext,   128'(0));
    check("rst_rk",   128'(rk_idx), 128'(0));
    saw_done = 1'b0;
    repeat (15) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("rst_no_done", 128'(saw_done), 128'(0));
    plaintext = PT_B; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, lat);
    check("ct_B_after_rst", ciphertext, CT_B);

    // hold after done
    repeat (20) begin
      tick();
      check("hold_ct",   ciphertext, CT_B);
      check("hold_busy", 128'(busy), 128'(0));
      check("hold_done", 128'(done), 128'(0));
    end

    // random keys, plaintexts, start noise and idle gaps
    for (int b = 0; b < 6; b++) begin
      expand_key(rand128());
      plaintext = rand128(); start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
        tick();
        lat++;
        plaintext = rand128();
        start = done ? 1'b0 : 1'($urandom_range(0, 1));
      end
      check("rand_latency", 128'(lat + 1), 128'(11));
      start = 1'b0;
      tick();
      repeat ($urandom_range(0, 3)) tick();
    end

    // start held high: re-accept in every IDLE cycle with fresh plaintext
    expand_key(rand128());
    start = 1'b1;
    repeat (40) begin
      plaintext = rand128();
      tick();
    end
    start = 1'b0;
    lat = 0;
    while (busy && lat < 15) begin
      tick();
      lat++;
    end
    check("held_start_drain", 128'(busy), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
